mm2x2_stream_loader: RTL and testbench

- Upstream and downstream companion for the 2x2 MAC-array multiplier.
- Accepts a serial valid/ready stream of 16-bit matrix elements and assembles operands A and B. Holds them stable on the multiplier operand ports for a fixed pipeline latency.
- Captures the four 32-bit products and returns them as a serial valid/ready result stream.
- Lets a narrow host or DMA channel drive the parallel-port multiplier one matrix pair at a time.

---
 rtl/mm2x2_stream_loader_if.sv | 33 +++
 rtl/mm2x2_stream_loader.sv | 118 +++++++++++
 tb/tb_mm2x2_stream_loader.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mm2x2_stream_loader_if.sv
// Stream and operand/product bundle between the loader, its 2x2 multiplier and the host.
// The slave modport is the loader's view; master is the host/multiplier side.
interface mm2x2_stream_loader_if #(
  parameter int DW = 16,
  parameter int RW = 32
);
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] mm_a00, mm_a01, mm_a10, mm_a11;
  logic [DW-1:0] mm_b00, mm_b01, mm_b10, mm_b11;
  logic [RW-1:0] mm_c00, mm_c01, mm_c10, mm_c11;
  logic [RW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;

  modport slave (
    input  in_data, in_valid, out_ready,
    input  mm_c00, mm_c01, mm_c10, mm_c11,
    output in_ready, out_data, out_valid, out_last,
    output mm_a00, mm_a01, mm_a10, mm_a11,
    output mm_b00, mm_b01, mm_b10, mm_b11
  );

  modport master (
    output in_data, in_valid, out_ready,
    output mm_c00, mm_c01, mm_c10, mm_c11,
    input  in_ready, out_data, out_valid, out_last,
    input  mm_a00, mm_a01, mm_a10, mm_a11,
    input  mm_b00, mm_b01, mm_b10, mm_b11
  );
endinterface

// File: rtl/mm2x2_stream_loader.sv
// Serial-to-parallel operand loader and parallel-to-serial result drain for a 2x2 MAC array.
// state | meaning
// LOAD  | accepting a00..b11 into the operand registers
// WAIT  | operands held while the multiplier pipeline fills
// DRAIN | presenting c00..c11 on the result stream
module mm2x2_stream_loader #(
  parameter int LATENCY = 2,
  parameter int DW      = 16,
  parameter int RW      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  mm2x2_stream_loader_if.slave  bus,
  output logic                  busy
);

  typedef enum logic [1:0] {ST_LOAD, ST_WAIT, ST_DRAIN} state_t;

  state_t        state_q, state_d;
  logic [2:0]    load_cnt_q, load_cnt_d;
  logic [3:0]    wait_cnt_q, wait_cnt_d;
  logic [1:0]    drain_cnt_q, drain_cnt_d;
  logic [DW-1:0] a_q [4];
  logic [DW-1:0] a_d [4];
  logic [DW-1:0] b_q [4];
  logic [DW-1:0] b_d [4];
  logic [RW-1:0] res_q [4];
  logic [RW-1:0] res_d [4];
  logic          rdy, vld, last;
  logic [RW-1:0] odata;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_LOAD;
      load_cnt_q  <= '0;
      wait_cnt_q  <= '0;
      drain_cnt_q <= '0;
      for (int i = 0; i < 4; i++) begin
        a_q[i]   <= '0;
        b_q[i]   <= '0;
        res_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      load_cnt_q  <= load_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_q       <= res_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    load_cnt_d  = load_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    drain_cnt_d = drain_cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    res_d       = res_q;
    rdy         = 1'b0;
    vld         = 1'b0;
    last        = 1'b0;
    odata       = '0;
    case (state_q)
      ST_LOAD: begin
        rdy = 1'b1;
        if (bus.in_valid) begin
          // load_cnt[2] selects A vs B, low bits the row-major element
          if (!load_cnt_q[2]) a_d[load_cnt_q[1:0]] = bus.in_data;
          else                b_d[load_cnt_q[1:0]] = bus.in_data;
          load_cnt_d = load_cnt_q + 3'd1;
          if (load_cnt_q == 3'd7) begin
            state_d    = ST_WAIT;
            wait_cnt_d = '0;
          end
        end
      end
      ST_WAIT: begin
        wait_cnt_d = wait_cnt_q + 4'd1;
        if (wait_cnt_q == 4'(LATENCY)) begin
          res_d[0]    = bus.mm_c00;
          res_d[1]    = bus.mm_c01;
          res_d[2]    = bus.mm_c10;
          res_d[3]    = bus.mm_c11;
          drain_cnt_d = '0;
          state_d     = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        vld   = 1'b1;
        odata = res_q[drain_cnt_q];
        last  = (drain_cnt_q == 2'd3);
        if (bus.out_ready) begin
          drain_cnt_d = drain_cnt_q + 2'd1;
          if (drain_cnt_q == 2'd3) state_d = ST_LOAD;
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  assign bus.in_ready  = rdy;
  assign bus.out_valid = vld;
  assign bus.out_last  = last;
  assign bus.out_data  = odata;
  assign bus.mm_a00    = a_q[0];
  assign bus.mm_a01    = a_q[1];
  assign bus.mm_a10    = a_q[2];
  assign bus.mm_a11    = a_q[3];
  assign bus.mm_b00    = b_q[0];
  assign bus.mm_b01    = b_q[1];
  assign bus.mm_b10    = b_q[2];
  assign bus.mm_b11    = b_q[3];
  assign busy          = (state_q != ST_LOAD);

endmodule

// File: tb/tb_mm2x2_stream_loader.sv
// Scoreboarded bench: matrix products computed from the operands sent, popped by a monitor on each result accept.
module tb_mm2x2_stream_loader;
  localparam int LAT = 2;

  logic clk;
  logic rst;
  logic busy;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   n_pop = 0;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } exp_t;
  exp_t exp_q[$];

  bit           prev_stall = 0, prev_valid = 0, chk_rdy_next = 0, expect_first = 0, chk_mm = 0;
  logic [31:0]  prev_data;
  int           e0 = 0;
  logic [127:0] cur_ops;

  mm2x2_stream_loader_if #(.DW(16), .RW(32)) bus ();

  mm2x2_stream_loader #(.LATENCY(LAT), .DW(16), .RW(32)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Multiplier stand-in: LAT register stages from operands to products
  logic [31:0] pipe [LAT][4];
  always @(posedge clk) begin
    pipe[0][0] <= 32'(bus.mm_a00) * 32'(bus.mm_b00) + 32'(bus.mm_a01) * 32'(bus.mm_b10);
    pipe[0][1] <= 32'(bus.mm_a00) * 32'(bus.mm_b01) + 32'(bus.mm_a01) * 32'(bus.mm_b11);
    pipe[0][2] <= 32'(bus.mm_a10) * 32'(bus.mm_b00) + 32'(bus.mm_a11) * 32'(bus.mm_b10);
    pipe[0][3] <= 32'(bus.mm_a10) * 32'(bus.mm_b01) + 32'(bus.mm_a11) * 32'(bus.mm_b11);
    for (int s = 1; s < LAT; s++) pipe[s] <= pipe[s-1];
  end
  assign bus.mm_c00 = pipe[LAT-1][0];
  assign bus.mm_c01 = pipe[LAT-1][1];
  assign bus.mm_c10 = pipe[LAT-1][2];
  assign bus.mm_c11 = pipe[LAT-1][3];

  function automatic logic [127:0] mm_ops();
    return {bus.mm_a00, bus.mm_a01, bus.mm_a10, bus.mm_a11,
            bus.mm_b00, bus.mm_b01, bus.mm_b10, bus.mm_b11};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic timeout(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timed out (cycle %0d)", nm, cyc);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      exp_t e;
      if (prev_stall) chk("stall_hold", {bus.out_valid, bus.out_data}, {1'b1, prev_data});
      if (chk_rdy_next) begin
        chk("ready_after_last", {bus.in_ready, bus.out_valid, busy}, 3'b100);
        chk_rdy_next = 0;
      end
      if (bus.out_valid) begin
        chk("ready_busy_in_drain", {bus.in_ready, busy}, 2'b01);
        if (!prev_valid && expect_first) begin
          chk("first_valid_latency", cyc - e0, LAT + 1);
          expect_first = 0;
        end
        if (bus.out_ready) begin
          prev_stall = 0;
          n_pop++;
          if (exp_q.size() == 0) begin
            timeout("unexpected_output");
          end else begin
            e = exp_q.pop_front();
            chk("out_data", bus.out_data, e.data);
            chk("out_last", bus.out_last, e.last);
            if (e.last) chk_rdy_next = 1;
          end
        end else begin
          prev_stall = 1;
          prev_data  = bus.out_data;
        end
      end else if (busy && chk_mm) begin
        chk("mm_hold_wait", mm_ops(), cur_ops);
      end
      prev_valid = bus.out_valid;
    end
  end

  task automatic do_reset(input int ncyc);
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    repeat (ncyc) @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    prev_stall   = 0;
    prev_valid   = 0;
    chk_rdy_next = 0;
    expect_first = 0;
    chk_mm       = 0;
    chk("reset_ctrl", {bus.in_ready, bus.out_valid, bus.out_last, busy}, 4'b1000);
    chk("reset_out_data", bus.out_data, 32'h0);
    chk("reset_mm", mm_ops(), 128'h0);
  endtask

  task automatic send_elem(input logic [15:0] d, input bit is_b11, input int gap);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) timeout("in_ready_wait");
    else if (is_b11) begin
      e0           = cyc + 1;
      expect_first = 1;
      chk_mm       = 1;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_data  = 16'($urandom);
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_exp(input logic [15:0] a [4], input logic [15:0] b [4]);
    exp_t e;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        e.data = '0;
        for (int k = 0; k < 2; k++) e.data += 32'(a[i*2+k]) * 32'(b[k*2+j]);
        e.last = (i == 1 && j == 1);
        exp_q.push_back(e);
      end
  endtask

  task automatic send_pair(input logic [15:0] a [4], input logic [15:0] b [4], input int gap);
    n_pop   = 0;
    cur_ops = {a[0], a[1], a[2], a[3], b[0], b[1], b[2], b[3]};
    push_exp(a, b);
    for (int i = 0; i < 8; i++) send_elem(i < 4 ? a[i] : b[i-4], i == 7, gap);
  endtask

  // mode 0: always ready, 1: stall c01 five cycles then toggle, 2: random
  task automatic drain(input int mode);
    int n = 0;
    int stall = 0;
    while (exp_q.size() > 0 && n < 300) begin
      if (mode == 0) bus.out_ready = 1'b1;
      else if (mode == 1) begin
        if (n_pop == 1 && stall < 5) begin
          bus.out_ready = 1'b0;
          stall++;
        end else if (n_pop >= 1 && stall >= 5) bus.out_ready = ~bus.out_ready;
        else bus.out_ready = 1'b1;
      end else bus.out_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      n++;
    end
    if (exp_q.size() > 0) timeout("drain");
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic run_pair(input logic [15:0] a [4], input logic [15:0] b [4], input int gap, input int mode);
    send_pair(a, b, gap);
    drain(mode);
  endtask

  initial begin
    logic [15:0] a1 [4] = '{16'd1, 16'd2, 16'd3, 16'd4};
    logic [15:0] b1 [4] = '{16'd5, 16'd6, 16'd7, 16'd8};
    logic [15:0] af [4] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    logic [15:0] a2 [4] = '{16'd2, 16'd0, 16'd0, 16'd2};
    logic [15:0] b2 [4] = '{16'd3, 16'd1, 16'd4, 16'd5};
    logic [15:0] ar [4];
    logic [15:0] br [4];
    int n;

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    do_reset(3);

    run_pair(a1, b1, 0, 0);
    run_pair(a1, b1, 3, 0);
    run_pair(a1, b1, 0, 1);
    run_pair(af, af, 0, 0);

    for (int i = 0; i < 5; i++) send_elem(a1[i % 4], 1'b0, 0);
    do_reset(1);
    run_pair(a2, b2, 0, 0);

    send_pair(a1, b1, 0);
    n = 0;
    while (n_pop < 2 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n_pop < 2) timeout("wait_drain_cnt2");
    bus.out_ready = 1'b0;
    do_reset(1);
    bus.out_ready = 1'b1;
    run_pair(a2, b2, 1, 0);

    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 4; i++) begin
        ar[i] = 16'($urandom);
        br[i] = 16'($urandom);
      end
      run_pair(ar, br, $urandom_range(0, 2), 2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
